// File: rtl/pong_pkg.sv
// Shared types and constants for the match controller: FSM states,
// BCD digit width, winner encodings and a BCD-to-binary helper.
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SERVE     = 2'd1,
    PLAY      = 2'd2,
    GAME_OVER = 2'd3
  } state_t;

  localparam int DIGIT_W = 4;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  function automatic logic [6:0] bcd_value(input logic [DIGIT_W-1:0] tens,
                                           input logic [DIGIT_W-1:0] unit);
    return 7'(tens) * 7'd10 + 7'(unit);
  endfunction

endpackage

// File: rtl/match_ctrl_if.sv
// Match controller bus: button/ball-logic inputs and score/status outputs.
// master = ball logic / board side, slave = match_ctrl.
interface match_ctrl_if;

  logic                         start;
  logic                         score1;
  logic                         score2;
  logic [pong_pkg::DIGIT_W-1:0] p1_unit;
  logic [pong_pkg::DIGIT_W-1:0] p1_tens;
  logic [pong_pkg::DIGIT_W-1:0] p2_unit;
  logic [pong_pkg::DIGIT_W-1:0] p2_tens;
  logic                         ball_freeze;
  logic                         serve;
  logic                         game_over;
  logic [1:0]                   winner;

  modport master (
    output start, score1, score2,
    input  p1_unit, p1_tens, p2_unit, p2_tens,
    input  ball_freeze, serve, game_over, winner
  );

  modport slave (
    input  start, score1, score2,
    output p1_unit, p1_tens, p2_unit, p2_tens,
    output ball_freeze, serve, game_over, winner
  );

endinterface

// File: rtl/match_ctrl_bcd2_counter.sv
// Two-digit BCD up-counter (00..99, wraps to 00) with synchronous clear.
module bcd2_counter
  import pong_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               inc,
  output logic [DIGIT_W-1:0] unit,
  output logic [DIGIT_W-1:0] tens
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      unit <= '0;
      tens <= '0;
    end else if (clr) begin
      unit <= '0;
      tens <= '0;
    end else if (inc) begin
      if (unit == 4'd9) begin
        unit <= '0;
        tens <= (tens == 4'd9) ? '0 : tens + 4'd1;
      end else begin
        unit <= unit + 4'd1;
      end
    end
  end

endmodule

// File: rtl/match_ctrl.sv
// Pong match controller: serve pause, point counting, win detection.
// All bus outputs come from registers or decode of registered state.
module match_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = 11,
  parameter int PAUSE_CYCLES = 100_000_000
) (
  input  logic         clk,
  input  logic         reset,
  match_ctrl_if.slave  bus
);

  localparam int             PW         = $clog2(PAUSE_CYCLES + 1);
  localparam logic [PW-1:0]  PAUSE_LAST = PW'(PAUSE_CYCLES - 1);
  localparam logic [6:0]     WIN_VAL    = 7'(WIN_SCORE);

  state_t              state, state_nx;
  logic [PW-1:0]       pause_cnt, pause_nx;
  logic [1:0]          winner, winner_nx;
  logic                start_p1, score1_p1, score2_p1;
  logic                start_edge, sc1_edge, sc2_edge;
  logic                clr, inc1, inc2;
  logic                p1_win, p2_win;
  logic [DIGIT_W-1:0]  p1_unit, p1_tens, p2_unit, p2_tens;

  assign start_edge = bus.start  & ~start_p1;
  assign sc1_edge   = bus.score1 & ~score1_p1;
  assign sc2_edge   = bus.score2 & ~score2_p1;

  // Win is judged on the score as it will be after this point is counted
  assign p1_win = (bcd_value(p1_tens, p1_unit) + 7'd1) == WIN_VAL;
  assign p2_win = (bcd_value(p2_tens, p2_unit) + 7'd1) == WIN_VAL;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pause_cnt <= '0;
      winner    <= WIN_NONE;
      start_p1  <= 1'b0;
      score1_p1 <= 1'b0;
      score2_p1 <= 1'b0;
    end else begin
      state     <= state_nx;
      pause_cnt <= pause_nx;
      winner    <= winner_nx;
      start_p1  <= bus.start;
      score1_p1 <= bus.score1;
      score2_p1 <= bus.score2;
    end
  end

  always_comb begin
    state_nx  = state;
    pause_nx  = pause_cnt;
    winner_nx = winner;
    clr       = 1'b0;
    inc1      = 1'b0;
    inc2      = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge) begin
          state_nx = SERVE;
          pause_nx = '0;
        end
      end
      SERVE: begin
        if (pause_cnt == PAUSE_LAST) state_nx = PLAY;
        else                         pause_nx = pause_cnt + 1'b1;
      end
      PLAY: begin
        // A tie of simultaneous edges is discarded outright
        if (sc1_edge && !sc2_edge) begin
          inc1 = 1'b1;
          if (p1_win) begin
            state_nx  = GAME_OVER;
            winner_nx = WIN_P1;
          end else begin
            state_nx = SERVE;
            pause_nx = '0;
          end
        end else if (sc2_edge && !sc1_edge) begin
          inc2 = 1'b1;
          if (p2_win) begin
            state_nx  = GAME_OVER;
            winner_nx = WIN_P2;
          end else begin
            state_nx = SERVE;
            pause_nx = '0;
          end
        end
      end
      GAME_OVER: begin
        if (start_edge) begin
          clr       = 1'b1;
          winner_nx = WIN_NONE;
          state_nx  = SERVE;
          pause_nx  = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  bcd2_counter u_p1_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (inc1),
    .unit  (p1_unit),
    .tens  (p1_tens)
  );

  bcd2_counter u_p2_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (inc2),
    .unit  (p2_unit),
    .tens  (p2_tens)
  );

  assign bus.p1_unit     = p1_unit;
  assign bus.p1_tens     = p1_tens;
  assign bus.p2_unit     = p2_unit;
  assign bus.p2_tens     = p2_tens;
  assign bus.winner      = winner;
  assign bus.ball_freeze = (state != PLAY);
  assign bus.game_over   = (state == GAME_OVER);
  assign bus.serve       = (state == SERVE) && (pause_cnt == PAUSE_LAST);

endmodule

// File: tb/tb_match_ctrl.sv
// Directed bench for match_ctrl: dut_a (WIN_SCORE=11) and dut_b (WIN_SCORE=3),
// both with PAUSE_CYCLES=4, sharing one 100 MHz clock.
module tb_match_ctrl;
  import pong_pkg::*;

  logic clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  logic rst_a, rst_b;
  int   n_vec = 0;
  int   n_err = 0;

  match_ctrl_if bus_a ();
  match_ctrl_if bus_b ();

  match_ctrl #(.WIN_SCORE(11), .PAUSE_CYCLES(4)) dut_a (
    .clk   (clk_100MHz),
    .reset (rst_a),
    .bus   (bus_a)
  );

  match_ctrl #(.WIN_SCORE(3), .PAUSE_CYCLES(4)) dut_b (
    .clk   (clk_100MHz),
    .reset (rst_b),
    .bus   (bus_b)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic set_in(input int d, input logic st, input logic s1, input logic s2);
    if (d == 0) begin
      bus_a.start = st; bus_a.score1 = s1; bus_a.score2 = s2;
    end else begin
      bus_b.start = st; bus_b.score1 = s1; bus_b.score2 = s2;
    end
  endtask

  function automatic int p1_of(input int d);
    return (d == 0) ? int'({bus_a.p1_tens, bus_a.p1_unit}) : int'({bus_b.p1_tens, bus_b.p1_unit});
  endfunction
  function automatic int p2_of(input int d);
    return (d == 0) ? int'({bus_a.p2_tens, bus_a.p2_unit}) : int'({bus_b.p2_tens, bus_b.p2_unit});
  endfunction
  function automatic int p2u_of(input int d);
    return (d == 0) ? int'(bus_a.p2_unit) : int'(bus_b.p2_unit);
  endfunction
  function automatic int frz_of(input int d);
    return (d == 0) ? int'(bus_a.ball_freeze) : int'(bus_b.ball_freeze);
  endfunction
  function automatic int srv_of(input int d);
    return (d == 0) ? int'(bus_a.serve) : int'(bus_b.serve);
  endfunction
  function automatic int go_of(input int d);
    return (d == 0) ? int'(bus_a.game_over) : int'(bus_b.game_over);
  endfunction
  function automatic int win_of(input int d);
    return (d == 0) ? int'(bus_a.winner) : int'(bus_b.winner);
  endfunction

  task automatic wait_play(input int d, output int serves);
    serves = 0;
    for (int i = 0; i < 40 && frz_of(d) == 1; i++) begin
      if (srv_of(d) == 1) serves++;
      tick();
    end
    chk("reach_play", frz_of(d), 0);
  endtask

  task automatic point(input int d, input logic s1, input logic s2);
    int srv;
    wait_play(d, srv);
    set_in(d, 1'b0, s1, s2);
    tick();
    set_in(d, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int srv;
    set_in(0, 1'b0, 1'b0, 1'b0);
    set_in(1, 1'b0, 1'b0, 1'b0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (2) tick();

    chk("rst_freeze", frz_of(0), 1);
    chk("rst_game_over", go_of(0), 0);
    chk("rst_serve", srv_of(0), 0);
    chk("rst_winner", win_of(0), 0);
    chk("rst_p1", p1_of(0), 8'h00);
    chk("rst_p2", p2_of(0), 8'h00);

    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (3) tick();
    chk("idle_hold", frz_of(0), 1);

    set_in(0, 1'b0, 1'b1, 1'b0);
    tick();
    set_in(0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("idle_score_ignored", p1_of(0), 8'h00);

    // Start: four frozen SERVE cycles, serve on the last, then PLAY
    set_in(0, 1'b1, 1'b0, 1'b0);
    tick();
    set_in(0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("serve_freeze", frz_of(0), 1);
      chk("serve_pulse", srv_of(0), (i == 3) ? 1 : 0);
      tick();
    end
    chk("play_unfrozen", frz_of(0), 0);
    chk("play_serve_low", srv_of(0), 0);

    // score1 held for five cycles counts once
    set_in(0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("hold_first", p1_of(0), 8'h01);
    chk("hold_to_serve", frz_of(0), 1);
    repeat (4) tick();
    chk("hold_once", p1_of(0), 8'h01);
    set_in(0, 1'b0, 1'b0, 1'b0);
    tick();

    wait_play(0, srv);
    set_in(0, 1'b0, 1'b1, 1'b1);
    tick();
    set_in(0, 1'b0, 1'b0, 1'b0);
    chk("tie_p1", p1_of(0), 8'h01);
    chk("tie_p2", p2_of(0), 8'h00);
    chk("tie_stays_play", frz_of(0), 0);
    tick();

    set_in(0, 1'b1, 1'b0, 1'b0);
    tick();
    set_in(0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("play_start_ignored", frz_of(0), 0);
    chk("play_start_no_go", go_of(0), 0);

    for (int i = 0; i < 10; i++) begin
      point(0, 1'b0, 1'b1);
      chk("p2_unit_bcd", (p2u_of(0) <= 9) ? 1 : 0, 1);
    end
    chk("p2_ten", p2_of(0), 8'h10);
    chk("p1_after_p2_run", p1_of(0), 8'h01);

    for (int i = 0; i < 4; i++) point(0, 1'b1, 1'b0);
    chk("p1_five", p1_of(0), 8'h05);
    chk("p1_five_in_serve", frz_of(0), 1);

    // Asynchronous reset in the middle of a clock period
    #2 rst_a = 1'b1;
    #1;
    chk("async_p1", p1_of(0), 8'h00);
    chk("async_p2", p2_of(0), 8'h00);
    chk("async_winner", win_of(0), 0);
    chk("async_freeze", frz_of(0), 1);
    chk("async_game_over", go_of(0), 0);
    tick();
    rst_a = 1'b0;
    srv = 0;
    for (int i = 0; i < 10; i++) begin
      if (srv_of(0) == 1) srv++;
      tick();
    end
    chk("post_reset_idle_serves", srv, 0);
    chk("post_reset_idle_freeze", frz_of(0), 1);

    // dut_b: match to 3
    set_in(1, 1'b1, 1'b0, 1'b0);
    tick();
    set_in(1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      point(1, 1'b1, 1'b0);
      if (k < 3) chk("b_not_over", go_of(1), 0);
    end
    chk("b_game_over", go_of(1), 1);
    chk("b_winner", win_of(1), 2'b01);
    chk("b_freeze", frz_of(1), 1);
    chk("b_p1", p1_of(1), 8'h03);

    set_in(1, 1'b0, 1'b0, 1'b1);
    tick();
    set_in(1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("b_over_score_ignored", p2_of(1), 8'h00);
    chk("b_still_over", go_of(1), 1);

    set_in(1, 1'b1, 1'b0, 1'b0);
    tick();
    set_in(1, 1'b0, 1'b0, 1'b0);
    chk("b_restart_p1", p1_of(1), 8'h00);
    chk("b_restart_p2", p2_of(1), 8'h00);
    chk("b_restart_winner", win_of(1), 0);
    chk("b_restart_go", go_of(1), 0);
    chk("b_restart_freeze", frz_of(1), 1);
    wait_play(1, srv);
    chk("b_restart_serves", srv, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
